// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - constants and types shared by fetch, decode and execute
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC   = 32'h0;
  localparam int unsigned PC_STEP    = 2;
  localparam int unsigned IMEM_DEPTH = 15;
  localparam int unsigned CNT_W      = 16;

  localparam logic [5:0] OP_ADD = 6'b000010;
  localparam logic [5:0] OP_BEQ = 6'b001011;
  localparam logic [5:0] OP_BNE = 6'b001100;
  localparam logic [5:0] OP_J   = 6'b001101;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// rtl/fetch_stage_if_id_reg.sv - IF/ID pipeline register with load/flush/hold
module fetch_stage_if_id_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc
);

  // Flush only drops valid; data and pc keep their last values.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      instr <= 32'h0;
      pc    <= 32'h0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= load_instr;
      pc    <= load_pc;
    end else if (flush) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC ownership, redirect, range/alignment halt
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = fetch_stage_pkg::RESET_PC,
  parameter int unsigned PC_STEP    = fetch_stage_pkg::PC_STEP,
  parameter int unsigned IMEM_DEPTH = fetch_stage_pkg::IMEM_DEPTH,
  parameter int unsigned CNT_W      = fetch_stage_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_data,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_target,
  output logic             if_valid,
  input  logic             if_ready,
  output logic [31:0]      if_instr,
  output logic [31:0]      if_pc,
  output logic             fetch_fault,
  output logic [CNT_W-1:0] fetch_count
);

  import fetch_stage_pkg::*;

  localparam logic [31:0] PC_MAX = 32'(2 * IMEM_DEPTH - 2);

  fetch_state_e state, state_n;
  logic [31:0]  pc, pc_n;
  logic         fault_n;
  logic         adv;
  logic         load;
  logic         flush;
  logic         consume;

  assign imem_addr = pc;
  assign consume   = if_valid && if_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      pc          <= RESET_PC;
      fetch_fault <= 1'b0;
      fetch_count <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      fetch_fault <= fault_n;
      if (consume && (fetch_count != {CNT_W{1'b1}}))
        fetch_count <= fetch_count + CNT_W'(1);
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    fault_n = fetch_fault;
    load    = 1'b0;
    adv     = (state == RUN) && (!if_valid || if_ready);
    if (redirect_valid) begin
      pc_n = redirect_target;
      if (redirect_target[0]) begin
        state_n = HALT;
        fault_n = 1'b1;
      end else if ((state == HALT) && (redirect_target > PC_MAX)) begin
        // A halted fetch only restarts on a target it can actually fetch.
        state_n = HALT;
      end else begin
        state_n = RUN;
      end
    end else if (adv) begin
      if (pc <= PC_MAX) begin
        load = 1'b1;
        pc_n = pc + 32'(PC_STEP);
      end else begin
        state_n = HALT;
        fault_n = 1'b1;
      end
    end
    flush = redirect_valid || (consume && !load);
  end

  fetch_stage_if_id_reg u_if_id_reg (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .flush      (flush),
    .load_instr (imem_data),
    .load_pc    (pc),
    .valid      (if_valid),
    .instr      (if_instr),
    .pc         (if_pc)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed vector bench for fetch_stage
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        rv;
    logic [31:0] tgt;
    logic        ev;
    logic [31:0] epc;
    int          ew;
    logic [31:0] eaddr;
    logic        ef;
    int          ecnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        fetch_fault;
  logic [15:0] fetch_count;

  logic [31:0] mem [64];
  vec_t        tv[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk             (clk),
    .reset           (reset),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .fetch_fault     (fetch_fault),
    .fetch_count     (fetch_count)
  );

  always_comb imem_data = mem[imem_addr[6:1]];

  function automatic logic [31:0] word(input int i);
    if (i < 0) return 32'h0;
    return {OP_ADD, 10'h0, 16'(16'hA000 + i)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic rdy, input logic rv, input logic [31:0] tgt,
                     input logic ev, input logic [31:0] epc, input int ew,
                     input logic [31:0] eaddr, input logic ef, input int ecnt);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.rv = rv; v.tgt = tgt;
    v.ev = ev; v.epc = epc; v.ew = ew; v.eaddr = eaddr; v.ef = ef; v.ecnt = ecnt;
    tv.push_back(v);
  endtask

  task automatic step(input logic rst, input logic rdy, input logic rv, input logic [31:0] tgt);
    reset = rst; if_ready = rdy; redirect_valid = rv; redirect_target = tgt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int          last_pc;
    logic [31:0] last_instr;
    bit          done;

    for (int i = 0; i < 64; i++) mem[i] = word(i);
    reset = 1'b1; if_ready = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;

    //   rst rdy rv tgt          v  if_pc wd  addr f  cnt
    add(1, 0, 0, 32'd0,        0, 0,  -1, 0,  0, 0);
    add(0, 1, 0, 32'd0,        1, 0,   0, 2,  0, 0);
    add(0, 1, 0, 32'd0,        1, 2,   1, 4,  0, 1);
    add(0, 1, 0, 32'd0,        1, 4,   2, 6,  0, 2);
    add(0, 1, 0, 32'd0,        1, 6,   3, 8,  0, 3);
    add(0, 1, 0, 32'd0,        1, 8,   4, 10, 0, 4);
    add(0, 1, 0, 32'd0,        1, 10,  5, 12, 0, 5);
    add(1, 1, 0, 32'd0,        0, 0,  -1, 0,  0, 0);
    add(0, 1, 0, 32'd0,        1, 0,   0, 2,  0, 0);
    add(0, 1, 0, 32'd0,        1, 2,   1, 4,  0, 1);
    add(0, 1, 0, 32'd0,        1, 4,   2, 6,  0, 2);
    add(0, 0, 0, 32'd0,        1, 4,   2, 6,  0, 2);
    add(0, 0, 0, 32'd0,        1, 4,   2, 6,  0, 2);
    add(0, 0, 0, 32'd0,        1, 4,   2, 6,  0, 2);
    add(0, 1, 0, 32'd0,        1, 6,   3, 8,  0, 3);
    for (int k = 4; k <= 12; k++)
      add(0, 1, 0, 32'd0,      1, 32'(2*k), k, 32'(2*k+2), 0, k);
    add(0, 1, 1, 32'd28,       0, 24, 12, 28, 0, 13);
    add(0, 1, 0, 32'd0,        1, 28, 14, 30, 0, 13);
    add(0, 1, 0, 32'd0,        0, 28, 14, 30, 1, 14);
    add(0, 1, 0, 32'd0,        0, 28, 14, 30, 1, 14);
    add(0, 1, 1, 32'd0,        0, 28, 14, 0,  1, 14);
    add(0, 1, 0, 32'd0,        1, 0,   0, 2,  1, 14);
    add(0, 0, 1, 32'd5,        0, 0,   0, 5,  1, 14);
    add(0, 1, 0, 32'd0,        0, 0,   0, 5,  1, 14);
    add(0, 1, 0, 32'd0,        0, 0,   0, 5,  1, 14);
    add(0, 0, 1, 32'd4,        0, 0,   0, 4,  1, 14);
    add(0, 0, 0, 32'd0,        1, 4,   2, 6,  1, 14);
    add(0, 0, 0, 32'd0,        1, 4,   2, 6,  1, 14);
    add(1, 0, 0, 32'd0,        0, 0,  -1, 0,  0, 0);
    add(0, 1, 0, 32'd0,        1, 0,   0, 2,  0, 0);

    foreach (tv[i]) begin
      step(tv[i].rst, tv[i].rdy, tv[i].rv, tv[i].tgt);
      check($sformatf("v%0d.valid", i), 32'(if_valid),    32'(tv[i].ev));
      check($sformatf("v%0d.if_pc", i), if_pc,            tv[i].epc);
      check($sformatf("v%0d.instr", i), if_instr,         word(tv[i].ew));
      check($sformatf("v%0d.addr", i),  imem_addr,        tv[i].eaddr);
      check($sformatf("v%0d.fault", i), 32'(fetch_fault), 32'(tv[i].ef));
      check($sformatf("v%0d.count", i), 32'(fetch_count), 32'(tv[i].ecnt));
    end

    // Free run from pc 0 until the range fault, bounded.
    last_pc = 0; last_instr = if_instr; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      step(0, 1, 0, 32'd0);
      if (if_valid) begin last_pc = int'(if_pc); last_instr = if_instr; end
      if (fetch_fault) done = 1;
    end
    check("run.reached_fault", 32'(done), 32'd1);
    check("run.last_pc", 32'(last_pc), 32'd28);
    check("run.last_instr", last_instr, word(14));
    check("run.count", 32'(fetch_count), 32'd15);
    check("run.addr_frozen", imem_addr, 32'd30);
    check("run.valid", 32'(if_valid), 32'd0);

    // Aligned but out-of-range redirect while halted keeps fetch halted.
    step(0, 1, 1, 32'h40);
    step(0, 1, 0, 32'd0);
    check("oor.valid", 32'(if_valid), 32'd0);
    check("oor.addr", imem_addr, 32'h40);
    step(0, 1, 1, 32'd2);
    step(0, 0, 0, 32'd0);
    check("resume.valid", 32'(if_valid), 32'd1);
    check("resume.if_pc", if_pc, 32'd2);
    check("resume.instr", if_instr, word(1));
    check("resume.fault_sticky", 32'(fetch_fault), 32'd1);
    check("resume.count", 32'(fetch_count), 32'd15);

    // Redirect to the top of the address space halts on the next fetch.
    step(1, 1, 0, 32'd0);
    step(0, 1, 1, 32'hFFFF_FFFE);
    step(0, 1, 0, 32'd0);
    check("wrap.fault", 32'(fetch_fault), 32'd1);
    check("wrap.valid", 32'(if_valid), 32'd0);
    check("wrap.addr", imem_addr, 32'hFFFF_FFFE);
    step(0, 1, 0, 32'd0);
    check("wrap.addr_hold", imem_addr, 32'hFFFF_FFFE);
    check("wrap.count", 32'(fetch_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
